// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: assembles up to three BCD digits, latches them on ENTER,
// and drives the multiplexed 7-segment refresh with leading-digit blanking.
module keypad_entry_ctrl #(
    parameter int REFRESH_DIV = 27000,
    parameter int N_DIG       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    output logic [3:0]  digit_out,
    output logic [2:0]  an,
    output logic [11:0] num_out,
    output logic        num_valid,
    output logic        overflow,
    output logic [1:0]  state_o
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = 4 * N_DIG;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    logic [1:0]    state_r, state_s;
    logic [BW-1:0] buf_r, buf_s;
    logic [1:0]    cnt_r, cnt_s;
    logic [11:0]   num_out_r, num_out_s;
    logic          num_valid_r, num_valid_s;
    logic          overflow_r, overflow_s;
    logic [CW-1:0] refresh_r;
    logic [1:0]    scan_r;
    logic [2:0]    an_r, an_s;
    logic [3:0]    digit_out_r, digit_out_s;
    logic          is_digit_s;

    assign is_digit_s = (key_code <= 4'd9);

    // Key-event decode and entry state machine next-state logic
    always_comb begin
        state_s     = state_r;
        buf_s       = buf_r;
        cnt_s       = cnt_r;
        num_out_s   = num_out_r;
        num_valid_s = 1'b0;
        overflow_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (key_valid && is_digit_s) begin
                    buf_s   = {8'h00, key_code};
                    cnt_s   = 2'd1;
                    state_s = ST_ENTRY;
                end else if (key_valid && (key_code == KEY_CLEAR)) begin
                    buf_s   = 12'h000;
                    cnt_s   = 2'd0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ENTRY: begin
                if (key_valid && is_digit_s) begin
                    if (cnt_r < 2'd3) begin
                        buf_s = {buf_r[7:0], key_code};
                        cnt_s = cnt_r + 2'd1;
                    end else begin
                        overflow_s = 1'b1;
                    end
                end else if (key_valid && (key_code == KEY_CLEAR)) begin
                    buf_s   = 12'h000;
                    cnt_s   = 2'd0;
                    state_s = ST_IDLE;
                end else if (key_valid && (key_code == KEY_ENTER)) begin
                    num_out_s   = buf_r;
                    num_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle entry
                state_s = ST_IDLE;
                buf_s   = 12'h000;
                cnt_s   = 2'd0;
            end
        endcase
    end

    // Display selection for the current scan position, blanking unentered digits
    always_comb begin
        an_s        = 3'b111;
        digit_out_s = 4'h0;
        if (scan_r < cnt_r) begin
            case (scan_r)
                2'd0: begin
                    an_s        = 3'b110;
                    digit_out_s = buf_r[3:0];
                end
                2'd1: begin
                    an_s        = 3'b101;
                    digit_out_s = buf_r[7:4];
                end
                2'd2: begin
                    an_s        = 3'b011;
                    digit_out_s = buf_r[11:8];
                end
                default: begin
                    an_s        = 3'b111;
                    digit_out_s = 4'h0;
                end
            endcase
        end else begin
            an_s        = 3'b111;
            digit_out_s = 4'h0;
        end
    end

    // Entry state and latched-number registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            buf_r       <= 12'h000;
            cnt_r       <= 2'd0;
            num_out_r   <= 12'h000;
            num_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            buf_r       <= buf_s;
            cnt_r       <= cnt_s;
            num_out_r   <= num_out_s;
            num_valid_r <= num_valid_s;
            overflow_r  <= overflow_s;
        end
    end

    // Refresh divider, scan index and registered display drive
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_r   <= '0;
            scan_r      <= 2'd0;
            an_r        <= 3'b111;
            digit_out_r <= 4'h0;
        end else begin
            an_r        <= an_s;
            digit_out_r <= digit_out_s;
            if (refresh_r == CW'(REFRESH_DIV - 1)) begin
                refresh_r <= '0;
                scan_r    <= (scan_r >= 2'd2) ? 2'd0 : (scan_r + 2'd1);
            end else begin
                refresh_r <= refresh_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign digit_out = digit_out_r;
    assign an        = an_r;
    assign num_out   = num_out_r;
    assign num_valid = num_valid_r;
    assign overflow  = overflow_r;
    assign state_o   = state_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl with a short refresh period.
module tb_keypad_entry_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [3:0]  digit_out;
    logic [2:0]  an;
    logic [11:0] num_out;
    logic        num_valid;
    logic        overflow;
    logic [1:0]  state_o;

    int checks;
    int errors;
    int nv_cnt;
    int ov_cnt;
    int both_cnt;
    int snap_nv;
    int snap_ov;
    int n110, n101, n011, n111, bad;

    keypad_entry_ctrl #(.REFRESH_DIV(4), .N_DIG(3)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .digit_out(digit_out), .an(an), .num_out(num_out), .num_valid(num_valid),
        .overflow(overflow), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, taken from the values held during the cycle ending at this edge
    always @(posedge clk) begin
        if (num_valid) nv_cnt++;
        if (overflow) ov_cnt++;
        if (num_valid && overflow) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic scan_window(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
        n110 = 0; n101 = 0; n011 = 0; n111 = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            case (an)
                3'b110: begin n110++; if (digit_out !== d0) bad++; end
                3'b101: begin n101++; if (digit_out !== d1) bad++; end
                3'b011: begin n011++; if (digit_out !== d2) bad++; end
                3'b111: begin n111++; if (digit_out !== 4'h0) bad++; end
                default: bad++;
            endcase
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        nv_cnt = 0; ov_cnt = 0; both_cnt = 0;
        reset = 1'b1; key_code = 4'h0; key_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and quiet idle period
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an !== 3'b111 || digit_out !== 4'h0) bad++;
        end
        check("idle_blank", bad, 0);
        check("rst_num_out", num_out, 12'h000);
        check("rst_state", state_o, 2'd0);
        check("idle_no_nv", nv_cnt, 0);
        check("idle_no_ov", ov_cnt, 0);

        // Enter 427
        press(4'd4);
        check("state_entry", state_o, 2'd1);
        press(4'd2);
        press(4'd7);
        snap_nv = nv_cnt;
        press(4'hB);
        check("nv_pulse_hi", num_valid, 1'b1);
        @(negedge clk);
        check("nv_pulse_lo", num_valid, 1'b0);
        check("nv_once", nv_cnt - snap_nv, 1);
        check("num_427", num_out, 12'h427);
        check("state_done", state_o, 2'd2);
        scan_window(4'd7, 4'd2, 4'd4);
        check("scan427_bad", bad, 0);
        check("scan427_an0", n110, 4);
        check("scan427_an1", n101, 4);
        check("scan427_an2", n011, 4);

        // ENTER while DONE is ignored
        snap_nv = nv_cnt;
        press(4'hB);
        repeat (2) @(negedge clk);
        check("done_enter_nv", nv_cnt - snap_nv, 0);
        check("done_enter_st", state_o, 2'd2);

        // Overflow on a fourth digit
        press(4'd1);
        check("done_digit_st", state_o, 2'd1);
        check("done_digit_num", num_out, 12'h427);
        press(4'd2);
        press(4'd3);
        snap_ov = ov_cnt;
        press(4'd9);
        check("ov_pulse_hi", overflow, 1'b1);
        @(negedge clk);
        check("ov_pulse_lo", overflow, 1'b0);
        check("ov_once", ov_cnt - snap_ov, 1);
        press(4'hB);
        check("num_123", num_out, 12'h123);

        // Single digit: only the units position lights
        press(4'd5);
        scan_window(4'd5, 4'd0, 4'd0);
        check("scan5_bad", bad, 0);
        check("scan5_an0", n110, 4);
        check("scan5_blank", n111, 8);
        press(4'hA);
        check("clear_state", state_o, 2'd0);
        @(negedge clk);
        check("clear_an", an, 3'b111);
        check("clear_num_kept", num_out, 12'h123);

        // ENTER and ignored code in IDLE
        snap_nv = nv_cnt;
        press(4'hB);
        repeat (2) @(negedge clk);
        check("idle_enter_nv", nv_cnt - snap_nv, 0);
        check("idle_enter_st", state_o, 2'd0);
        press(4'hD);
        check("ignored_code", state_o, 2'd0);

        // Reset coincident with a digit at cnt=2
        press(4'd1);
        press(4'd2);
        @(negedge clk);
        reset = 1'b1; key_code = 4'd3; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key_code = 4'h0;
        check("rk_state", state_o, 2'd0);
        check("rk_num_out", num_out, 12'h000);
        check("rk_an", an, 3'b111);
        check("rk_digit", digit_out, 4'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rk_an_after", an, 3'b111);
        check("rk_state_after", state_o, 2'd0);
        check("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
